// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//   Shared types and constants for the oversampling UART receiver.
//   - rx_state_e     : receiver FSM states
//   - PRESC_8/16/32  : supported oversampling ratios
//   - CNT_W          : width of the per-bit edge counter (holds up to 32)
//   - prescale_eff() : maps a raw Prescale value onto a supported ratio
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] PRESC_8  = 6'd8;
  localparam logic [CNT_W-1:0] PRESC_16 = 6'd16;
  localparam logic [CNT_W-1:0] PRESC_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Unsupported ratios (including 0) fall back to dflt. With a 5-bit
  // Prescale port the value 32 cannot be expressed and decodes as dflt.
  function automatic logic [CNT_W-1:0] prescale_eff(input logic [CNT_W-1:0] presc,
                                                   input logic [CNT_W-1:0] dflt);
    logic [CNT_W-1:0] res;
    case (presc)
      PRESC_8, PRESC_16, PRESC_32: res = presc;
      default:                     res = dflt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//   Per-bit timing for the UART receiver: edge counter 0..P-1, sample-point
//   decode and bit value recovery.
//   Build option: UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote over the
//   samples at P/2-1, P/2 and P/2+1; otherwise a single sample at P/2.
//   Ports:
//     clk            oversampling clock
//     rst            asynchronous active-low reset
//     rx_i           serial line
//     run_i          advance the edge counter (receiver busy)
//     clr_i          restart the edge counter at 0 (start detected)
//     presc_i        effective oversampling ratio P
//     bit_value_o    recovered bit value, final when sample_done_o is high
//     sample_done_o  edge counter is at P/2+1
//     bit_done_o     edge counter is at P-1 (last cycle of the bit)
// ---------------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] presc_i,
  output logic             bit_value_o,
  output logic             sample_done_o,
  output logic             bit_done_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] cnt_last, cnt_mid, cnt_late;
  logic             s_mid_q;

  assign cnt_last = presc_i - CNT_ONE;
  assign cnt_mid  = presc_i >> 1;
  assign cnt_late = cnt_mid + CNT_ONE;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (clr_i) begin
      edge_cnt_d = '0;
    end else if (run_i) begin
      if (edge_cnt_q == cnt_last) edge_cnt_d = '0;
      else                        edge_cnt_d = edge_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt_q <= '0;
    else      edge_cnt_q <= edge_cnt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 s_mid_q <= 1'b1;
    else if (run_i && edge_cnt_q == cnt_mid)  s_mid_q <= rx_i;
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [CNT_W-1:0] cnt_early;
  logic             s_early_q;

  assign cnt_early = cnt_mid - CNT_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  s_early_q <= 1'b1;
    else if (run_i && edge_cnt_q == cnt_early) s_early_q <= rx_i;
  end

  // The third sample is the live line during P/2+1; it is consumed by the
  // FSM registers on the same edge that would have stored it here.
  assign bit_value_o = (s_early_q & s_mid_q) | (s_early_q & rx_i) | (s_mid_q & rx_i);
`else
  assign bit_value_o = s_mid_q;
`endif

  assign sample_done_o = run_i && (edge_cnt_q == cnt_late);
  assign bit_done_o    = run_i && (edge_cnt_q == cnt_last);

endmodule

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   Oversampling UART receiver: start detect, 8 data bits LSB-first,
//   optional even/odd parity, one stop bit. Delivers the byte on P_DATA with
//   a one-cycle data_valid strobe and flags parity/framing errors.
//   Build option: UART_RX_MAJORITY_VOTE_EN (see uart_rx_sampler).
//   RX_IN is expected to be synchronous to clk.
//   Ports:
//     clk            oversampling clock (Prescale x baud)
//     rst            asynchronous active-low reset
//     RX_IN          serial line, idle high
//     PAR_EN         frame carries a parity bit
//     PAR_TYP        0 even, 1 odd parity
//     Prescale       oversampling ratio 8/16/32, anything else acts as PRESC_DEF
//     P_DATA         last error-free byte
//     data_valid     one-cycle strobe with a new P_DATA
//     parity_error   parity mismatch in the current/last frame
//     framing_error  stop bit sampled low in the current/last frame
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low level
//   START  | start bit; a high sample means glitch -> IDLE
//   DATA   | shifting in data bits LSB-first
//   PARITY | checking the parity bit
//   STOP   | checking the stop bit, delivering the byte
// ---------------------------------------------------------------------------
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PRESC_W   = 5,
  parameter int PRESC_DEF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [PRESC_W-1:0] Prescale,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              parity_error,
  output logic              framing_error
);

  localparam int                BCNT_W   = $clog2(DATA_W);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);
  localparam logic [CNT_W-1:0]  DEF_P    = CNT_W'(PRESC_DEF);

  rx_state_e         state_q, state_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] p_data_q, p_data_d;
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_error_q, parity_error_d;
  logic              framing_error_q, framing_error_d;

  logic              start_det;
  logic              bit_value, sample_done, bit_done;
  logic              exp_par;

  uart_rx_sampler u_sampler (
    .clk           (clk),
    .rst           (rst),
    .rx_i          (RX_IN),
    .run_i         (state_q != IDLE),
    .clr_i         (start_det),
    .presc_i       (presc_q),
    .bit_value_o   (bit_value),
    .sample_done_o (sample_done),
    .bit_done_o    (bit_done)
  );

  assign exp_par = par_typ_q ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    p_data_d        = p_data_q;
    presc_d         = presc_q;
    par_en_d        = par_en_q;
    par_typ_d       = par_typ_q;
    data_valid_d    = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    start_det       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!RX_IN) start_det = 1'b1;
      end
      START: begin
        if (sample_done && bit_value) begin
          state_d = IDLE;
        end else if (bit_done) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample_done) shift_d = {bit_value, shift_q[DATA_W-1:1]};
        if (bit_done) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_ONE;
          end
        end
      end
      PARITY: begin
        if (sample_done && (bit_value != exp_par)) parity_error_d = 1'b1;
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (sample_done && !bit_value) framing_error_d = 1'b1;
        if (bit_done) begin
          // Framing is sampled at P/2+1, so both flags are settled here.
          if (!parity_error_q && !framing_error_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          if (!RX_IN) start_det = 1'b1;
          else        state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Start detection (from IDLE or directly after a stop bit) latches the
    // frame configuration and clears the previous frame's error flags.
    if (start_det) begin
      state_d         = START;
      bit_cnt_d       = '0;
      par_en_d        = PAR_EN;
      par_typ_d       = PAR_TYP;
      presc_d         = prescale_eff(CNT_W'(Prescale), DEF_P);
      parity_error_d  = 1'b0;
      framing_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      p_data_q        <= '0;
      presc_q         <= DEF_P;
      par_en_q        <= 1'b0;
      par_typ_q       <= 1'b0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      p_data_q        <= p_data_d;
      presc_q         <= presc_d;
      par_en_q        <= par_en_d;
      par_typ_q       <= par_typ_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign P_DATA        = p_data_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
//   Directed bench for uart_rx_core: reset state, back-to-back frames at
//   P=8, parity frames at P=16, glitch rejection, parity and framing errors,
//   reset mid-frame and reception after reset with a fallback Prescale.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;
  import uart_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [4:0] Prescale = 5'd0;
  logic [7:0] P_DATA;
  logic       data_valid, parity_error, framing_error;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int vld_cyc = 0;
  int long_cnt = 0;
  logic prev_dv = 1'b0;
  logic [7:0] cap [0:63];

  uart_rx_core dut (
    .clk           (clk),
    .rst           (rst),
    .RX_IN         (RX_IN),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .Prescale      (Prescale),
    .P_DATA        (P_DATA),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records each strobe, its byte and its cycle.
  always @(negedge clk) begin
    if (rst && data_valid) begin
      if (vld_cnt < 64) cap[vld_cnt] = P_DATA;
      vld_cnt = vld_cnt + 1;
      vld_cyc = cyc;
      if (prev_dv) long_cnt = long_cnt + 1;
    end
    prev_dv = rst && data_valid;
  end

  function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic pen,
                                           input logic pbit, input logic stop);
    if (pen) return {1'b0, stop, pbit, d, 1'b0};
    else     return {2'b00, stop, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [11:0] bits, input int n, input int p);
    for (int i = 0; i < n; i++) begin
      RX_IN = bits[i];
      repeat (p) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; RX_IN = 1'b0; Prescale = 5'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL reset_pdata: got %h want %h", P_DATA, 8'h00); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_cmp++; if (parity_error !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", parity_error); end
    n_cmp++; if (framing_error !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", framing_error); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = vld_cnt;
    send_bits(mk_frame(8'hCC, 1'b0, 1'b0, 1'b1), 10, 8);
    send_bits(mk_frame(8'h07, 1'b0, 1'b0, 1'b1), 10, 8);
    idle(4);
    n_cmp++; if (vld_cnt - v0 !== 2) begin n_err++; $display("FAIL b2b_count: got %0d pulses want 2", vld_cnt - v0); end
    n_cmp++; if (cap[v0] !== 8'hCC) begin n_err++; $display("FAIL b2b_byte0: got %h want cc", cap[v0]); end
    n_cmp++; if (cap[v0+1] !== 8'h07) begin n_err++; $display("FAIL b2b_byte1: got %h want 07", cap[v0+1]); end
    n_cmp++; if ({parity_error, framing_error} !== 2'b00) begin n_err++; $display("FAIL b2b_flags: got %b%b want 00", parity_error, framing_error); end
  endtask

  task automatic test_parity_ok;
    int v0, s, lat;
    Prescale = 5'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    idle(3);
    v0 = vld_cnt;
    s  = cyc;
    send_bits(mk_frame(8'hA5, 1'b1, 1'b0, 1'b1), 11, 16);
    idle(4);
    lat = vld_cyc - s;
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_err++; $display("FAIL par_ok_count: got %0d pulses want 1", vld_cnt - v0); end
    n_cmp++; if (cap[v0] !== 8'hA5) begin n_err++; $display("FAIL par_ok_byte: got %h want a5", cap[v0]); end
    n_cmp++; if (parity_error !== 1'b0) begin n_err++; $display("FAIL par_ok_perr: got %b want 0", parity_error); end
    n_cmp++; if (lat < 175 || lat > 177) begin n_err++; $display("FAIL par_ok_latency: got %0d cycles want 176+-1", lat); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vld_cnt;
    RX_IN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(200);
    n_cmp++; if (vld_cnt !== v0) begin n_err++; $display("FAIL glitch_count: got %0d pulses want 0", vld_cnt - v0); end
    n_cmp++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL glitch_pdata: got %h want a5", P_DATA); end
    n_cmp++; if ({parity_error, framing_error} !== 2'b00) begin n_err++; $display("FAIL glitch_flags: got %b%b want 00", parity_error, framing_error); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL glitch_state: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_parity_error;
    int v0;
    v0 = vld_cnt;
    send_bits(mk_frame(8'hA5, 1'b1, 1'b1, 1'b1), 11, 16);
    idle(4);
    n_cmp++; if (vld_cnt !== v0) begin n_err++; $display("FAIL perr_count: got %0d pulses want 0", vld_cnt - v0); end
    n_cmp++; if (parity_error !== 1'b1) begin n_err++; $display("FAIL perr_flag: got %b want 1", parity_error); end
    n_cmp++; if (framing_error !== 1'b0) begin n_err++; $display("FAIL perr_ferr: got %b want 0", framing_error); end
    n_cmp++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL perr_pdata: got %h want a5", P_DATA); end
  endtask

  task automatic test_framing_error;
    int v0;
    v0 = vld_cnt;
    send_bits(mk_frame(8'h3C, 1'b1, 1'b0, 1'b0), 11, 16);
    idle(4);
    n_cmp++; if (vld_cnt !== v0) begin n_err++; $display("FAIL ferr_count: got %0d pulses want 0", vld_cnt - v0); end
    n_cmp++; if (framing_error !== 1'b1) begin n_err++; $display("FAIL ferr_flag: got %b want 1", framing_error); end
    n_cmp++; if (parity_error !== 1'b0) begin n_err++; $display("FAIL ferr_perr: got %b want 0", parity_error); end
    n_cmp++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL ferr_pdata: got %h want a5", P_DATA); end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    v0 = vld_cnt;
    send_bits(mk_frame(8'hFF, 1'b1, 1'b0, 1'b1), 4, 16);
    rst = 1'b0;
    #2;
    n_cmp++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL midrst_pdata: got %h want 00", P_DATA); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", data_valid); end
    n_cmp++; if ({parity_error, framing_error} !== 2'b00) begin n_err++; $display("FAIL midrst_flags: got %b%b want 00", parity_error, framing_error); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want %0d", dut.state_q, IDLE); end
    RX_IN = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    n_cmp++; if (vld_cnt !== v0) begin n_err++; $display("FAIL midrst_count: got %0d pulses want 0", vld_cnt - v0); end
  endtask

  task automatic test_after_reset;
    int v0, s, lat;
    Prescale = 5'd31; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    idle(3);
    v0 = vld_cnt;
    s  = cyc;
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1, 1'b1), 11, 8);
    idle(4);
    lat = vld_cyc - s;
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_err++; $display("FAIL post_count: got %0d pulses want 1", vld_cnt - v0); end
    n_cmp++; if (cap[v0] !== 8'h5A) begin n_err++; $display("FAIL post_byte: got %h want 5a", cap[v0]); end
    n_cmp++; if ({parity_error, framing_error} !== 2'b00) begin n_err++; $display("FAIL post_flags: got %b%b want 00", parity_error, framing_error); end
    n_cmp++; if (lat < 87 || lat > 89) begin n_err++; $display("FAIL post_latency: got %0d cycles want 88+-1", lat); end
  endtask

  task automatic test_pulse_width;
    n_cmp++; if (long_cnt !== 0) begin n_err++; $display("FAIL pulse_width: got %0d multi-cycle strobes want 0", long_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_back_to_back;
    test_parity_ok;
    test_glitch;
    test_parity_error;
    test_framing_error;
    test_reset_mid_frame;
    test_after_reset;
    test_pulse_width;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
